tmc_spi_scan_sched: RTL and testbench

//  Hardware scan scheduler for the shared temperature-board SPI bus (4 boards x 3 ADC chip selects).

---
 rtl/tmc_spi_scan_sched.sv | 175 +++++++++++++++++
 tb/tb_tmc_spi_scan_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmc_spi_scan_sched.sv
// Scan scheduler for the shared temperature-board SPI bus: walks 12 ADC channels per scan period,
// skipping ineligible boards, policing each SPI transaction with a timeout and posting results.
module tmc_spi_scan_sched #(
    parameter int unsigned P_SCAN_PERIOD_CLKS = 500000,
    parameter int unsigned P_TIMEOUT_CLKS     = 50000,
    parameter int unsigned P_DATA_W           = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [3:0]          board_en,
    input  logic [3:0]          live,
    output logic                spi_req,
    output logic [3:0]          spi_cs_idx,
    input  logic                spi_done,
    input  logic [P_DATA_W-1:0] spi_rdata,
    output logic                result_wr,
    output logic [3:0]          result_idx,
    output logic [P_DATA_W-1:0] result_data,
    output logic                scan_done,
    output logic                timeout_err,
    output logic [3:0]          err_idx,
    output logic                overrun,
    input  logic                err_clr
);

    localparam int unsigned PerW = (P_SCAN_PERIOD_CLKS > 1) ? $clog2(P_SCAN_PERIOD_CLKS) : 1;
    localparam int unsigned ToW  = $clog2(P_TIMEOUT_CLKS + 1);
    localparam logic [PerW-1:0] PerLast = PerW'(P_SCAN_PERIOD_CLKS - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(P_TIMEOUT_CLKS - 1);
    localparam logic [3:0]      IdxLast = 4'd11;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StSel,
        StReq,
        StWr,
        StNext
    } state_e;

    state_e              state_q, state_d;
    logic [PerW-1:0]     per_q, per_d;
    logic [ToW-1:0]      to_q, to_d;
    logic [3:0]          idx_q, idx_d;
    logic [P_DATA_W-1:0] data_q, data_d;
    logic                terr_q, terr_d;
    logic [3:0]          eidx_q, eidx_d;
    logic                ovr_q, ovr_d;
    logic                tick;
    logic [3:0]          board_ok;
    logic [11:0]         elig_mask;

    // One eligibility bit per channel; three chip selects share each board.
    assign board_ok  = board_en & live;
    assign elig_mask = {{3{board_ok[3]}}, {3{board_ok[2]}}, {3{board_ok[1]}}, {3{board_ok[0]}}};

    always_comb begin
        tick  = 1'b0;
        per_d = per_q;
        if (!enable) begin
            per_d = '0;
        end else if (per_q == PerLast) begin
            per_d = '0;
            tick  = 1'b1;
        end else begin
            per_d = per_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        to_d      = to_q;
        data_d    = data_q;
        terr_d    = terr_q;
        eidx_d    = eidx_q;
        ovr_d     = ovr_q;
        spi_req   = 1'b0;
        result_wr = 1'b0;
        scan_done = 1'b0;

        // Sets below override the clear when both land in the same cycle.
        if (err_clr) begin
            terr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (tick && (state_q != StWaitTick)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (enable) state_d = StWaitTick;
            end
            StWaitTick: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    idx_d   = '0;
                    state_d = StSel;
                end
            end
            StSel: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (elig_mask[idx_q]) begin
                    to_d    = '0;
                    state_d = StReq;
                end else begin
                    state_d = StNext;
                end
            end
            StReq: begin
                spi_req = 1'b1;
                if (spi_done) begin
                    data_d  = spi_rdata;
                    state_d = StWr;
                end else if (to_q == ToLast) begin
                    terr_d  = 1'b1;
                    eidx_d  = idx_q;
                    state_d = StNext;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StWr: begin
                result_wr = 1'b1;
                state_d   = StNext;
            end
            StNext: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (idx_q == IdxLast) begin
                    scan_done = 1'b1;
                    state_d   = StWaitTick;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StSel;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            per_q   <= '0;
            to_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            terr_q  <= 1'b0;
            eidx_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            to_q    <= to_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            terr_q  <= terr_d;
            eidx_q  <= eidx_d;
            ovr_q   <= ovr_d;
        end
    end

    assign spi_cs_idx  = (state_q == StReq) ? idx_q : 4'd0;
    assign result_idx  = (state_q == StWr) ? idx_q : 4'd0;
    assign result_data = data_q;
    assign timeout_err = terr_q;
    assign err_idx     = eidx_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_tmc_spi_scan_sched.sv
// Directed bench for tmc_spi_scan_sched with a small SPI responder and a result monitor.
module tb_tmc_spi_scan_sched;

    localparam int unsigned PER = 100;
    localparam int unsigned TO  = 20;
    localparam int unsigned DW  = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [3:0]    board_en = 4'hF;
    logic [3:0]    live = 4'hF;
    logic          spi_req;
    logic [3:0]    spi_cs_idx;
    logic          spi_done = 1'b0;
    logic [DW-1:0] spi_rdata = '0;
    logic          result_wr;
    logic [3:0]    result_idx;
    logic [DW-1:0] result_data;
    logic          scan_done;
    logic          timeout_err;
    logic [3:0]    err_idx;
    logic          overrun;
    logic          err_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    int model_delay = 5;
    int no_ans = -1;
    int req_age = 0;

    int            res_idx[$];
    logic [DW-1:0] res_data[$];
    int            done_cnt = 0;
    int            bad_cs = 0;
    int            req_cnt = 0;

    always #5 clk = ~clk;

    tmc_spi_scan_sched #(
        .P_SCAN_PERIOD_CLKS(PER),
        .P_TIMEOUT_CLKS    (TO),
        .P_DATA_W          (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .board_en   (board_en),
        .live       (live),
        .spi_req    (spi_req),
        .spi_cs_idx (spi_cs_idx),
        .spi_done   (spi_done),
        .spi_rdata  (spi_rdata),
        .result_wr  (result_wr),
        .result_idx (result_idx),
        .result_data(result_data),
        .scan_done  (scan_done),
        .timeout_err(timeout_err),
        .err_idx    (err_idx),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    // SPI master model: answers model_delay cycles after req rises, unless idx == no_ans.
    always @(negedge clk) begin
        if (spi_req && !spi_done) begin
            req_age = req_age + 1;
            if (req_age == model_delay && int'(spi_cs_idx) != no_ans) begin
                spi_done  = 1'b1;
                spi_rdata = DW'(spi_cs_idx * 16'h1111);
            end
        end else begin
            spi_done = 1'b0;
            req_age  = 0;
        end
    end

    always @(negedge clk) begin
        if (result_wr) begin
            res_idx.push_back(int'(result_idx));
            res_data.push_back(result_data);
        end
        if (scan_done) done_cnt = done_cnt + 1;
        if (spi_req) begin
            req_cnt = req_cnt + 1;
            if (spi_cs_idx inside {[4'd3:4'd5], [4'd9:4'd11]}) bad_cs = bad_cs + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        res_idx.delete();
        res_data.delete();
        done_cnt = 0;
        bad_cs   = 0;
        req_cnt  = 0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!scan_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, scan_done, 1);
    endtask

    task automatic wait_req_idx(input int idx, input int budget, input string tag);
        int n = 0;
        while (!(spi_req && int'(spi_cs_idx) == idx) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, spi_req, 1);
    endtask

    task automatic stop_scan();
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int hits;
        int snap;
        int exp2[6] = '{0, 1, 2, 6, 7, 8};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst spi_req", spi_req, 0);
        check("rst cs_idx", spi_cs_idx, 0);
        check("rst result_wr", result_wr, 0);
        check("rst result_data", result_data, 0);
        check("rst scan_done", scan_done, 0);
        check("rst timeout_err", timeout_err, 0);
        check("rst err_idx", err_idx, 0);
        check("rst overrun", overrun, 0);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();

        // 1: all channels live, 5-cycle SPI answers
        enable = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!spi_req && n < 300);
        check("t1 req latency", n, 101);
        check("t1 first cs", spi_cs_idx, 0);
        wait_done(400, "t1 scan_done");
        stop_scan();
        check("t1 result count", res_idx.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < res_idx.size()) begin
                check($sformatf("t1 idx%0d", i), res_idx[i], i);
                check($sformatf("t1 data%0d", i), {8'h0, res_data[i]}, i * 32'h1111);
            end
        end
        check("t1 scan_done count", done_cnt, 1);
        check("t1 overrun", overrun, 0);
        check("t1 timeout_err", timeout_err, 0);

        // 2: boards a and c only
        clear_mon();
        board_en = 4'b0101;
        enable = 1'b1;
        wait_done(400, "t2 scan_done");
        stop_scan();
        check("t2 result count", res_idx.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < res_idx.size()) check($sformatf("t2 idx%0d", i), res_idx[i], exp2[i]);
        end
        check("t2 cs on b/d", bad_cs, 0);
        check("t2 scan_done count", done_cnt, 1);

        // 3: channel 4 never answers
        clear_mon();
        board_en = 4'hF;
        no_ans = 4;
        enable = 1'b1;
        wait_req_idx(4, 400, "t3 reach idx4");
        n = 0;
        while (spi_req && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("t3 req hold", n, 20);
        check("t3 timeout_err", timeout_err, 1);
        check("t3 err_idx", err_idx, 4);
        wait_done(400, "t3 scan_done");
        stop_scan();
        hits = 0;
        foreach (res_idx[k]) if (res_idx[k] == 4) hits++;
        check("t3 result count", res_idx.size(), 11);
        check("t3 idx4 posted", hits, 0);
        if (res_idx.size() > 0) check("t3 last idx", res_idx[res_idx.size()-1], 11);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3 err cleared", timeout_err, 0);
        check("t3 overrun cleared", overrun, 0);

        // 4: slow channels, scan overruns the next tick
        clear_mon();
        no_ans = -1;
        model_delay = 15;
        enable = 1'b1;
        wait_done(600, "t4 scan_done");
        stop_scan();
        check("t4 overrun", overrun, 1);
        check("t4 timeout_err", timeout_err, 0);
        check("t4 result count", res_idx.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < res_idx.size()) check($sformatf("t4 idx%0d", i), res_idx[i], i);
        end
        check("t4 scan_done count", done_cnt, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t4 overrun cleared", overrun, 0);

        // 5: drop enable mid-transaction at idx 7
        clear_mon();
        model_delay = 10;
        enable = 1'b1;
        wait_req_idx(7, 400, "t5 reach idx7");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("t5 req held", spi_req, 1);
        check("t5 cs held", spi_cs_idx, 7);
        n = 0;
        while (res_idx.size() < 8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("t5 result count", res_idx.size(), 8);
        if (res_idx.size() > 0) check("t5 last idx", res_idx[res_idx.size()-1], 7);
        check("t5 req dropped", spi_req, 0);
        snap = req_cnt;
        repeat (200) @(negedge clk);
        check("t5 idle req", req_cnt, snap);
        check("t5 scan_done count", done_cnt, 0);

        // 5b: reset while a request is outstanding
        enable = 1'b1;
        n = 0;
        while (!spi_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t5b req seen", spi_req, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5b req after rst", spi_req, 0);
        check("t5b cs after rst", spi_cs_idx, 0);
        enable = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 6: nothing live
        clear_mon();
        model_delay = 5;
        live = 4'h0;
        enable = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!scan_done && n < 300);
        check("t6 scan_done time", n, 123);
        stop_scan();
        check("t6 req never", req_cnt, 0);
        check("t6 scan_done count", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
